// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the carry chain is cut into STAGES chunks of WIDTH/STAGES bits,
// each resolved in its own registered stage, with valid/ready flow control on both sides.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SafeStages = (STAGES == 0) ? 1 : STAGES;
  localparam int unsigned CW         = WIDTH / SafeStages;
  localparam int unsigned Last       = SafeStages - 1;
  localparam bit          BadCfg     = (STAGES == 0) || ((WIDTH % SafeStages) != 0);

  if (BadCfg) begin : g_param_check
    $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
  end

  // Whole pipe freezes while the output beat is refused.
  logic w_stall;
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  for (genvar k = 0; k < SafeStages; k++) begin : g_stage
    localparam int unsigned Lo = k * CW;
    localparam int unsigned Hi = Lo + CW;

    // Operand bits not yet consumed, and result bits resolved so far including this chunk.
    logic [WIDTH-1:Lo] w_a;
    logic [WIDTH-1:Lo] w_b;
    logic              w_c;
    logic              w_v;
    logic [CW:0]       w_chunk;
    logic [Hi-1:0]     w_s;

    logic [Hi-1:0]     r_s;
    logic              r_c;
    logic              r_v;

    if (k == 0) begin : g_head
      assign w_a = a;
      assign w_b = sub ? ~b : b;
      assign w_c = cin ^ sub;
      assign w_v = in_valid;
      assign w_s = w_chunk[CW-1:0];
    end else begin : g_tail
      assign w_a = g_stage[k-1].g_fwd.r_a;
      assign w_b = g_stage[k-1].g_fwd.r_b;
      assign w_c = g_stage[k-1].r_c;
      assign w_v = g_stage[k-1].r_v;
      assign w_s = {w_chunk[CW-1:0], g_stage[k-1].r_s};
    end

    assign w_chunk = {1'b0, w_a[Hi-1:Lo]} + {1'b0, w_b[Hi-1:Lo]} + {{CW{1'b0}}, w_c};

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (!w_stall) begin
        r_v <= w_v;
        if (w_v) begin
          r_s <= w_s;
          r_c <= w_chunk[CW];
        end
      end
    end

    if (k < Last) begin : g_fwd
      // Skew registers: only the operand bits still waiting for a later stage travel on.
      logic [WIDTH-1:Hi] r_a;
      logic [WIDTH-1:Hi] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (!w_stall && w_v) begin
          r_a <= w_a[WIDTH-1:Hi];
          r_b <= w_b[WIDTH-1:Hi];
        end
      end
    end else begin : g_flags
      logic w_ovf;
      logic w_zero;
      logic r_ovf;
      logic r_zero;

      assign w_ovf  = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_s[WIDTH-1] != w_a[WIDTH-1]);
      assign w_zero = (w_s == '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (!w_stall && w_v) begin
          r_ovf  <= w_ovf;
          r_zero <= w_zero;
        end
      end
    end
  end

  assign out_valid = g_stage[Last].r_v;
  assign sum       = g_stage[Last].r_s;
  assign cout      = g_stage[Last].r_c;
  assign overflow  = g_stage[Last].g_flags.r_ovf;
  assign zero      = g_stage[Last].g_flags.r_zero;

endmodule
